// File: rtl/fir_coef_loader.sv
// Runtime FIR coefficient programmer: streams a frame into a shadow bank, then commits it
// atomically to the active bank together with the frame's DC gain.
module fir_coef_loader #(
    parameter int unsigned NTAPS = 24,
    parameter int unsigned CW    = 10,
    parameter int unsigned AW    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        cin_valid,
    input  logic signed [CW-1:0]        cin_data,
    output logic                        cin_ready,
    output logic [NTAPS*CW-1:0]         coef_flat,
    output logic                        coef_update,
    output logic signed [CW+AW-1:0]     dc_gain,
    output logic                        busy,
    output logic                        err
);

    typedef enum logic [1:0] {StIdle, StLoad, StSwap} state_e;

    localparam logic [AW-1:0] LastIdx = AW'(NTAPS - 1);

    state_e                    state_q, state_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic signed [CW+AW-1:0]   acc_q, acc_d;
    logic [NTAPS*CW-1:0]       shadow_q, shadow_d;
    logic [NTAPS*CW-1:0]       active_q, active_d;
    logic signed [CW+AW-1:0]   gain_q, gain_d;
    logic                      update_q, update_d;
    logic                      err_q, err_d;
    logic                      busy_q, busy_d;
    logic                      xfer;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        gain_d    = gain_q;
        update_d  = 1'b0;
        err_d     = 1'b0;
        cin_ready = (state_q == StLoad);
        xfer      = cin_valid && cin_ready;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            StLoad: begin
                // A restart wins over a same-cycle transfer; that word is dropped.
                if (start) begin
                    err_d = 1'b1;
                    idx_d = '0;
                    acc_d = '0;
                end else if (xfer) begin
                    for (int k = 0; k < NTAPS; k++) begin
                        if (idx_q == AW'(k)) shadow_d[k*CW +: CW] = cin_data;
                    end
                    acc_d = acc_q + {{AW{cin_data[CW-1]}}, cin_data};
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LastIdx) state_d = StSwap;
                end
            end
            StSwap: begin
                active_d = shadow_q;
                gain_d   = acc_q;
                update_d = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            acc_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            gain_q   <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            gain_q   <= gain_d;
            update_q <= update_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign coef_flat   = active_q;
    assign dc_gain     = gain_q;
    assign coef_update = update_q;
    assign err         = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: hand-computed frames, immediate-assertion checks.
module tb_fir_coef_loader;

    localparam int NTAPS = 24;
    localparam int CW    = 10;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  cin_valid;
    logic [CW-1:0]         cin_data;
    logic                  cin_ready;
    logic [NTAPS*CW-1:0]   coef_flat;
    logic                  coef_update;
    logic [CW+AW-1:0]      dc_gain;
    logic                  busy;
    logic                  err;

    fir_coef_loader #(.NTAPS(NTAPS), .CW(CW), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cin_valid   (cin_valid),
        .cin_data    (cin_data),
        .cin_ready   (cin_ready),
        .coef_flat   (coef_flat),
        .coef_update (coef_update),
        .dc_gain     (dc_gain),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;
    int upd_cnt  = 0;
    int err_cnt  = 0;
    int ready_hi = 0;

    logic [CW-1:0]       frame [NTAPS];
    logic [NTAPS*CW-1:0] f2_flat;
    int                  f2 [12] = '{-1, -2, 4, 5, -8, -11, 15, 20, -29, -43, 75, 231};

    always @(negedge clk) begin
        if (coef_update) upd_cnt++;
        if (err)         err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    endtask

    function automatic logic [NTAPS*CW-1:0] frame_flat();
        logic [NTAPS*CW-1:0] f;
        for (int k = 0; k < NTAPS; k++) f[k*CW +: CW] = frame[k];
        return f;
    endfunction

    // Offer words first..last-1 of frame; optional idle cycle before each word.
    task automatic send_words(input int first, input int last, input bit gappy);
        for (int n = first; n < last; n++) begin
            if (gappy) begin
                cin_valid = 1'b0;
                cin_data  = 10'h155;
                tick();
            end
            cin_valid = 1'b1;
            cin_data  = frame[n];
            if (cin_ready) ready_hi++;
            tick();
        end
        cin_valid = 1'b0;
    endtask

    // Called right after the last handshake edge: SWAP cycle, then commit cycle.
    task automatic check_commit(input string tag, input logic [CW+AW-1:0] gain);
        int u0;
        u0 = upd_cnt;
        chk({tag, "_swap_upd"}, coef_update, 1'b0);
        chk({tag, "_swap_busy"}, busy, 1'b1);
        chk({tag, "_swap_ready"}, cin_ready, 1'b0);
        tick();
        chk({tag, "_upd"}, coef_update, 1'b1);
        chk({tag, "_flat"}, coef_flat, frame_flat());
        chk({tag, "_gain"}, dc_gain, gain);
        chk({tag, "_busy"}, busy, 1'b0);
        tick();
        chk({tag, "_upd_fall"}, coef_update, 1'b0);
        chk({tag, "_upd_cnt"}, upd_cnt - u0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        cin_valid = 1'b0;
        cin_data  = '0;

        // Reset
        tick();
        tick();
        chk("rst_flat", coef_flat, '0);
        chk("rst_gain", dc_gain, '0);
        chk("rst_ready", cin_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_upd", coef_update, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        // Symmetric frame, continuous
        for (int k = 0; k < 12; k++) begin
            frame[k]      = 10'(f2[k]);
            frame[23 - k] = 10'(f2[k]);
        end
        f2_flat  = frame_flat();
        start    = 1'b1;
        tick();
        start    = 1'b0;
        ready_hi = 0;
        chk("t2_busy", busy, 1'b1);
        send_words(0, NTAPS, 1'b0);
        chk("t2_ready_cnt", ready_hi, 24);
        check_commit("t2", 15'd512);
        chk("t2_tap0", coef_flat[9:0], 10'h3FF);
        chk("t2_tap11", coef_flat[11*CW +: CW], 10'd231);
        chk("t2_tap23", coef_flat[23*CW +: CW], 10'h3FF);

        // Words offered in IDLE are ignored; gappy frame gives the same result
        cin_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cin_data = 10'(n + 100);
            chk("t3_idle_ready", cin_ready, 1'b0);
            tick();
        end
        cin_valid = 1'b0;
        chk("t3_idle_flat", coef_flat, f2_flat);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(0, NTAPS, 1'b1);
        check_commit("t3", 15'd512);

        // Restart mid-frame, then a frame of all +1
        err_cnt = 0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        send_words(0, 10, 1'b0);
        start     = 1'b1;
        cin_valid = 1'b1;
        cin_data  = 10'h1FF;
        tick();
        start     = 1'b0;
        cin_valid = 1'b0;
        chk("t4_err", err, 1'b1);
        chk("t4_hold_flat", coef_flat, f2_flat);
        for (int k = 0; k < NTAPS; k++) frame[k] = 10'd1;
        send_words(0, NTAPS, 1'b0);
        chk("t4_hold_gain", dc_gain, 15'd512);
        check_commit("t4", 15'd24);
        chk("t4_err_cnt", err_cnt, 1);

        // Reset mid-frame
        for (int k = 0; k < NTAPS; k++) frame[k] = 10'(k + 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(0, 12, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_flat", coef_flat, '0);
        chk("t5_gain", dc_gain, '0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_ready", cin_ready, 1'b0);
        chk("t5_upd", coef_update, 1'b0);
        chk("t5_err", err, 1'b0);
        cin_valid = 1'b1;
        cin_data  = 10'd9;
        tick();
        tick();
        cin_valid = 1'b0;
        chk("t5_idle_ready", cin_ready, 1'b0);
        chk("t5_upd_after", coef_update, 1'b0);
        chk("t5_flat_after", coef_flat, '0);

        // Extreme values
        for (int k = 0; k < NTAPS; k++) frame[k] = 10'h200;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(0, NTAPS, 1'b0);
        check_commit("t6_min", 15'h5000);
        for (int k = 0; k < NTAPS; k++) frame[k] = 10'h1FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(0, NTAPS, 1'b0);
        check_commit("t6_max", 15'd12264);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
